// File: rtl/mon_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mon_frame_ctrl
// Description : Monitoring-frame controller for the end-of-column monitoring
//               path. Loads register read-back words into per-lane FIFOs,
//               tracks full-lane drops with sticky flags and a saturating
//               counter, and on each frame request tops up empty lanes with
//               default data, reads one word per lane and strobes the frame
//               writer after a fixed delay.
// Revision    : 1.0 - initial release
// ============================================================================
module mon_frame_ctrl #(
    parameter int N_LANES   = 8,
    parameter int WR_DLY    = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 Reset_b,
    input  logic [N_LANES-1:0]   LaneEn,
    input  logic [N_LANES-1:0]   FifoEmpty,
    input  logic [N_LANES-1:0]   FifoFull,
    input  logic                 NewRegData,
    input  logic                 SendFrame,
    input  logic                 ErrClear,
    output logic [N_LANES-1:0]   LoadData,
    output logic [N_LANES-1:0]   FifoFullError,
    output logic [N_LANES-1:0]   FifoFullErrSticky,
    output logic [ERR_CNT_W-1:0] ErrCount,
    output logic [N_LANES-1:0]   LoadDefaultData,
    output logic [N_LANES-1:0]   RdFifo,
    output logic                 WrData,
    output logic                 Busy,
    output logic                 FrameOverrun
);

    // Delay counter is wide enough for the largest legal WR_DLY (7)
    localparam int                 CNT_W    = 3;
    localparam logic [CNT_W-1:0]   DLY_INIT = CNT_W'(WR_DLY - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READ  = 2'd2,
        DELAY = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   dly_cnt;
    logic [CNT_W-1:0]   next_cnt;
    logic [N_LANES-1:0] next_load_def;
    logic [N_LANES-1:0] next_rd;
    logic               next_wr;
    logic               next_overrun;

    // Read-back classification for the current cycle; zero when no word arrives
    logic [N_LANES-1:0] load_now;
    logic [N_LANES-1:0] err_now;
    logic               any_err;

    assign load_now = NewRegData ? (LaneEn & ~FifoFull) : '0;
    assign err_now  = NewRegData ? (LaneEn &  FifoFull) : '0;
    assign any_err  = |err_now;

    // Read-back path: route each word to enabled lanes, flag drops on full lanes
    always_ff @(posedge clk or negedge Reset_b) begin
        if (!Reset_b) begin
            LoadData      <= '0;
            FifoFullError <= '0;
        end else begin
            LoadData      <= load_now;
            FifoFullError <= err_now;
        end
    end

    // Sticky flags and saturating error counter; a new error wins over clear
    always_ff @(posedge clk or negedge Reset_b) begin
        if (!Reset_b) begin
            FifoFullErrSticky <= '0;
            ErrCount          <= '0;
        end else if (ErrClear) begin
            FifoFullErrSticky <= err_now;
            ErrCount          <= any_err ? ERR_CNT_W'(1) : '0;
        end else begin
            FifoFullErrSticky <= FifoFullErrSticky | err_now;
            if (any_err && (ErrCount != ERR_MAX)) begin
                ErrCount <= ErrCount + ERR_CNT_W'(1);
            end
        end
    end

    // Frame sequencer: next state, delay count and next registered strobes
    always_comb begin
        next_state    = state;
        next_cnt      = dly_cnt;
        next_load_def = '0;
        next_rd       = '0;
        next_wr       = 1'b0;
        next_overrun  = 1'b0;
        case (state)
            IDLE: begin
                if (SendFrame) begin
                    next_state    = FILL;
                    // Lanes taking a read-back word this edge are not empty
                    next_load_def = LaneEn & FifoEmpty & ~load_now;
                end
            end
            FILL: begin
                next_state = READ;
                next_rd    = LaneEn;
            end
            READ: begin
                next_state = DELAY;
                next_cnt   = DLY_INIT;
                next_wr    = (DLY_INIT == '0);
            end
            DELAY: begin
                if (dly_cnt == '0) begin
                    next_state = IDLE;
                end else begin
                    next_cnt = dly_cnt - CNT_W'(1);
                    next_wr  = (dly_cnt == CNT_W'(1));
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        // Any request while a sequence is running, including the WrData cycle, is dropped
        if ((state != IDLE) && SendFrame) begin
            next_overrun = 1'b1;
        end
    end

    // Sequencer state register and registered frame outputs
    always_ff @(posedge clk or negedge Reset_b) begin
        if (!Reset_b) begin
            state           <= IDLE;
            dly_cnt         <= '0;
            LoadDefaultData <= '0;
            RdFifo          <= '0;
            WrData          <= 1'b0;
            Busy            <= 1'b0;
            FrameOverrun    <= 1'b0;
        end else begin
            state           <= next_state;
            dly_cnt         <= next_cnt;
            LoadDefaultData <= next_load_def;
            RdFifo          <= next_rd;
            WrData          <= next_wr;
            Busy            <= (next_state != IDLE);
            FrameOverrun    <= next_overrun;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mon_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mon_frame_ctrl
// Description : Directed self-checking bench for mon_frame_ctrl. A second
//               instance with a 2-bit error counter exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mon_frame_ctrl;

    logic       clk;
    logic       Reset_b;
    logic [7:0] LaneEn;
    logic [7:0] FifoEmpty;
    logic [7:0] FifoFull;
    logic       NewRegData;
    logic       SendFrame;
    logic       ErrClear;

    logic [7:0] LoadData, FifoFullError, FifoFullErrSticky, LoadDefaultData, RdFifo;
    logic [7:0] ErrCount;
    logic       WrData, Busy, FrameOverrun;

    logic [7:0] s_LoadData, s_FifoFullError, s_FifoFullErrSticky, s_LoadDefaultData, s_RdFifo;
    logic [1:0] s_ErrCount;
    logic       s_WrData, s_Busy, s_FrameOverrun;

    int n_cmp;
    int n_err;

    mon_frame_ctrl #(.N_LANES(8), .WR_DLY(2), .ERR_CNT_W(8)) u_dut (
        .clk(clk), .Reset_b(Reset_b), .LaneEn(LaneEn), .FifoEmpty(FifoEmpty),
        .FifoFull(FifoFull), .NewRegData(NewRegData), .SendFrame(SendFrame),
        .ErrClear(ErrClear), .LoadData(LoadData), .FifoFullError(FifoFullError),
        .FifoFullErrSticky(FifoFullErrSticky), .ErrCount(ErrCount),
        .LoadDefaultData(LoadDefaultData), .RdFifo(RdFifo), .WrData(WrData),
        .Busy(Busy), .FrameOverrun(FrameOverrun)
    );

    mon_frame_ctrl #(.N_LANES(8), .WR_DLY(2), .ERR_CNT_W(2)) u_dut_sat (
        .clk(clk), .Reset_b(Reset_b), .LaneEn(LaneEn), .FifoEmpty(FifoEmpty),
        .FifoFull(FifoFull), .NewRegData(NewRegData), .SendFrame(SendFrame),
        .ErrClear(ErrClear), .LoadData(s_LoadData), .FifoFullError(s_FifoFullError),
        .FifoFullErrSticky(s_FifoFullErrSticky), .ErrCount(s_ErrCount),
        .LoadDefaultData(s_LoadDefaultData), .RdFifo(s_RdFifo), .WrData(s_WrData),
        .Busy(s_Busy), .FrameOverrun(s_FrameOverrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        Reset_b = 1'b0;
        #3;
        n_cmp++; if (LoadData !== 8'h00) begin n_err++; $display("FAIL rst_load got=%h exp=00", LoadData); end
        n_cmp++; if (FifoFullError !== 8'h00) begin n_err++; $display("FAIL rst_ferr got=%h exp=00", FifoFullError); end
        n_cmp++; if (FifoFullErrSticky !== 8'h00) begin n_err++; $display("FAIL rst_sticky got=%h exp=00", FifoFullErrSticky); end
        n_cmp++; if (ErrCount !== 8'h00) begin n_err++; $display("FAIL rst_cnt got=%h exp=00", ErrCount); end
        n_cmp++; if (LoadDefaultData !== 8'h00) begin n_err++; $display("FAIL rst_ldd got=%h exp=00", LoadDefaultData); end
        n_cmp++; if (RdFifo !== 8'h00) begin n_err++; $display("FAIL rst_rd got=%h exp=00", RdFifo); end
        n_cmp++; if ({WrData, Busy, FrameOverrun} !== 3'b000) begin n_err++; $display("FAIL rst_ctl got=%b exp=000", {WrData, Busy, FrameOverrun}); end
        tick();
        tick();
        Reset_b = 1'b1;
        tick();
    endtask

    task automatic test_default_fill();
        LaneEn = 8'hFF; FifoEmpty = 8'h0F; FifoFull = 8'h00;
        SendFrame = 1'b1;
        tick();                        // cycle k+1
        SendFrame = 1'b0;
        n_cmp++; if (LoadDefaultData !== 8'h0F) begin n_err++; $display("FAIL fill_ldd got=%h exp=0f", LoadDefaultData); end
        n_cmp++; if (Busy !== 1'b1) begin n_err++; $display("FAIL fill_busy1 got=%b exp=1", Busy); end
        n_cmp++; if (RdFifo !== 8'h00) begin n_err++; $display("FAIL fill_rd_early got=%h exp=00", RdFifo); end
        tick();                        // cycle k+2
        n_cmp++; if (RdFifo !== 8'hFF) begin n_err++; $display("FAIL fill_rd got=%h exp=ff", RdFifo); end
        n_cmp++; if (LoadDefaultData !== 8'h00) begin n_err++; $display("FAIL fill_ldd_off got=%h exp=00", LoadDefaultData); end
        tick();                        // cycle k+3
        n_cmp++; if ({WrData, Busy} !== 2'b01) begin n_err++; $display("FAIL fill_k3 got=%b exp=01", {WrData, Busy}); end
        tick();                        // cycle k+4
        n_cmp++; if ({WrData, Busy} !== 2'b11) begin n_err++; $display("FAIL fill_wr got=%b exp=11", {WrData, Busy}); end
        tick();                        // cycle k+5
        n_cmp++; if ({WrData, Busy} !== 2'b00) begin n_err++; $display("FAIL fill_done got=%b exp=00", {WrData, Busy}); end
    endtask

    task automatic test_full_error();
        ErrClear = 1'b1;
        tick();
        ErrClear = 1'b0;
        LaneEn = 8'h7F; FifoFull = 8'h81; FifoEmpty = 8'h00;
        NewRegData = 1'b1;
        tick();
        NewRegData = 1'b0;
        n_cmp++; if (LoadData !== 8'h7E) begin n_err++; $display("FAIL ferr_load got=%h exp=7e", LoadData); end
        n_cmp++; if (FifoFullError !== 8'h01) begin n_err++; $display("FAIL ferr_err got=%h exp=01", FifoFullError); end
        n_cmp++; if (FifoFullErrSticky !== 8'h01) begin n_err++; $display("FAIL ferr_sticky got=%h exp=01", FifoFullErrSticky); end
        n_cmp++; if (ErrCount !== 8'd1) begin n_err++; $display("FAIL ferr_cnt got=%0d exp=1", ErrCount); end
        tick();
        n_cmp++; if ({LoadData, FifoFullError} !== 16'h0000) begin n_err++; $display("FAIL ferr_pulse got=%h exp=0000", {LoadData, FifoFullError}); end
        n_cmp++; if (FifoFullErrSticky !== 8'h01) begin n_err++; $display("FAIL ferr_hold got=%h exp=01", FifoFullErrSticky); end
    endtask

    task automatic test_saturation();
        // Both counters start at 1 from the previous error cycle
        NewRegData = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        NewRegData = 1'b0;
        n_cmp++; if (s_ErrCount !== 2'd3) begin n_err++; $display("FAIL sat_cnt got=%0d exp=3", s_ErrCount); end
        n_cmp++; if (ErrCount !== 8'd6) begin n_err++; $display("FAIL sat_cnt8 got=%0d exp=6", ErrCount); end
        ErrClear = 1'b1; NewRegData = 1'b1; FifoFull = 8'h02;
        tick();
        NewRegData = 1'b0;
        n_cmp++; if (s_ErrCount !== 2'd1) begin n_err++; $display("FAIL clr_new_cnt got=%0d exp=1", s_ErrCount); end
        n_cmp++; if (ErrCount !== 8'd1) begin n_err++; $display("FAIL clr_new_cnt8 got=%0d exp=1", ErrCount); end
        n_cmp++; if (FifoFullErrSticky !== 8'h02) begin n_err++; $display("FAIL clr_new_sticky got=%h exp=02", FifoFullErrSticky); end
        tick();
        ErrClear = 1'b0;
        n_cmp++; if (ErrCount !== 8'd0) begin n_err++; $display("FAIL clr_cnt got=%0d exp=0", ErrCount); end
        n_cmp++; if (FifoFullErrSticky !== 8'h00) begin n_err++; $display("FAIL clr_sticky got=%h exp=00", FifoFullErrSticky); end
        FifoFull = 8'h00;
    endtask

    task automatic test_collision();
        LaneEn = 8'hFF; FifoEmpty = 8'hFF; FifoFull = 8'h00;
        NewRegData = 1'b1; SendFrame = 1'b1;
        tick();
        NewRegData = 1'b0; SendFrame = 1'b0;
        n_cmp++; if (LoadData !== 8'hFF) begin n_err++; $display("FAIL col_load got=%h exp=ff", LoadData); end
        n_cmp++; if (LoadDefaultData !== 8'h00) begin n_err++; $display("FAIL col_ldd got=%h exp=00", LoadDefaultData); end
        tick();
        n_cmp++; if (RdFifo !== 8'hFF) begin n_err++; $display("FAIL col_rd got=%h exp=ff", RdFifo); end
        tick(); tick(); tick();
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL col_idle got=%b exp=0", Busy); end
    endtask

    task automatic test_lane_disable();
        LaneEn = 8'h00; FifoEmpty = 8'hFF; FifoFull = 8'hF0;
        NewRegData = 1'b1; SendFrame = 1'b1;
        tick();
        NewRegData = 1'b0; SendFrame = 1'b0;
        n_cmp++; if ({LoadData, FifoFullError} !== 16'h0000) begin n_err++; $display("FAIL dis_rb got=%h exp=0000", {LoadData, FifoFullError}); end
        n_cmp++; if ({LoadDefaultData, Busy} !== 9'h001) begin n_err++; $display("FAIL dis_fill got=%h exp=001", {LoadDefaultData, Busy}); end
        tick();
        n_cmp++; if (RdFifo !== 8'h00) begin n_err++; $display("FAIL dis_rd got=%h exp=00", RdFifo); end
        tick(); tick();
        n_cmp++; if (WrData !== 1'b1) begin n_err++; $display("FAIL dis_wr got=%b exp=1", WrData); end
        tick();
        FifoFull = 8'h00;
    endtask

    task automatic test_overrun();
        int wr_cnt;
        int ovr_cnt;
        wr_cnt = 0; ovr_cnt = 0;
        LaneEn = 8'hFF; FifoEmpty = 8'h00;
        SendFrame = 1'b1;
        tick();                        // k+1
        SendFrame = 1'b0;
        if (WrData) wr_cnt++;
        tick();                        // k+2
        SendFrame = 1'b1;
        if (WrData) wr_cnt++;
        tick();                        // k+3
        SendFrame = 1'b0;
        n_cmp++; if (FrameOverrun !== 1'b1) begin n_err++; $display("FAIL ovr_pulse got=%b exp=1", FrameOverrun); end
        for (int i = 0; i < 8; i++) begin
            if (WrData) wr_cnt++;
            if (FrameOverrun) ovr_cnt++;
            tick();
        end
        n_cmp++; if (wr_cnt !== 1) begin n_err++; $display("FAIL ovr_wr_count got=%0d exp=1", wr_cnt); end
        n_cmp++; if (ovr_cnt !== 1) begin n_err++; $display("FAIL ovr_count got=%0d exp=1", ovr_cnt); end
    endtask

    task automatic test_back_to_back();
        LaneEn = 8'hFF; FifoEmpty = 8'h0F;
        SendFrame = 1'b1;
        tick();                        // k+1
        SendFrame = 1'b0;
        tick(); tick(); tick();        // k+4, WrData cycle
        n_cmp++; if (WrData !== 1'b1) begin n_err++; $display("FAIL b2b_wr got=%b exp=1", WrData); end
        SendFrame = 1'b1;              // sampled while still busy
        tick();                        // k+5
        n_cmp++; if ({FrameOverrun, Busy, LoadDefaultData} !== 10'h200) begin n_err++; $display("FAIL b2b_drop got=%h exp=200", {FrameOverrun, Busy, LoadDefaultData}); end
        tick();                        // accepted 5 edges after the first
        SendFrame = 1'b0;
        n_cmp++; if ({FrameOverrun, Busy, LoadDefaultData} !== 10'h10F) begin n_err++; $display("FAIL b2b_accept got=%h exp=10f", {FrameOverrun, Busy, LoadDefaultData}); end
        for (int i = 0; i < 5; i++) tick();
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle got=%b exp=0", Busy); end
    endtask

    task automatic test_reset_mid();
        int wr_cnt;
        wr_cnt = 0;
        LaneEn = 8'hFF; FifoEmpty = 8'h0F; FifoFull = 8'h01;
        SendFrame = 1'b1; NewRegData = 1'b1;
        tick();                        // k+1
        SendFrame = 1'b0; NewRegData = 1'b0; FifoFull = 8'h00;
        n_cmp++; if (FifoFullErrSticky !== 8'h01) begin n_err++; $display("FAIL mid_sticky_pre got=%h exp=01", FifoFullErrSticky); end
        tick(); tick();                // k+3, in DELAY
        #2;
        Reset_b = 1'b0;
        #1;
        n_cmp++; if ({WrData, Busy, RdFifo, LoadDefaultData} !== 18'h0) begin n_err++; $display("FAIL mid_async got=%h exp=0", {WrData, Busy, RdFifo, LoadDefaultData}); end
        n_cmp++; if ({FifoFullErrSticky, ErrCount} !== 16'h0000) begin n_err++; $display("FAIL mid_errclr got=%h exp=0000", {FifoFullErrSticky, ErrCount}); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (WrData) wr_cnt++;
        end
        Reset_b = 1'b1;
        tick();
        if (WrData) wr_cnt++;
        n_cmp++; if (wr_cnt !== 0) begin n_err++; $display("FAIL mid_nowr got=%0d exp=0", wr_cnt); end
        SendFrame = 1'b1;
        tick();
        SendFrame = 1'b0;
        n_cmp++; if ({Busy, LoadDefaultData} !== 9'h10F) begin n_err++; $display("FAIL mid_restart got=%h exp=10f", {Busy, LoadDefaultData}); end
        tick();
        n_cmp++; if (RdFifo !== 8'hFF) begin n_err++; $display("FAIL mid_rd got=%h exp=ff", RdFifo); end
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0; n_err = 0;
        Reset_b = 1'b0; LaneEn = 8'hFF; FifoEmpty = 8'h00; FifoFull = 8'h00;
        NewRegData = 1'b0; SendFrame = 1'b0; ErrClear = 1'b0;
        test_reset();
        test_default_fill();
        test_full_error();
        test_saturation();
        test_collision();
        test_lane_disable();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mon_frame_ctrl.md
# mon_frame_ctrl

Parametrised monitoring-frame controller in the end-of-column monitoring path. It fills N per-lane monitoring FIFOs with register read-back data and, on each frame request, tops up every enabled empty lane with default data, reads one word from every enabled lane and strobes the frame writer. It adds lane masking, frame sequencing with overrun detection, sticky full-error flags and a saturating error counter.

## Interface

- N_LANES, 8, number of monitoring FIFOs/lanes (1..8)
- WR_DLY, 2, cycles from RdFifo pulse to WrData pulse (1..7)
- ERR_CNT_W, 8, width of ErrCount

- clk  input  1  160 MHz clock, single clock domain
- Reset_b  input  1  reset, asynchronous assert, active low
- LaneEn  input  N_LANES  per-lane enable; disabled lanes are never loaded, read or flagged
- FifoEmpty  input  N_LANES  per-lane FIFO empty
- FifoFull  input  N_LANES  per-lane FIFO full
- NewRegData  input  1  register read-back word available, one-cycle pulse
- SendFrame  input  1  frame request, one-cycle pulse
- ErrClear  input  1  clears FifoFullErrSticky and ErrCount
- LoadData  output  N_LANES  write read-back word into lane FIFO
- FifoFullError  output  N_LANES  pulse: read-back word dropped on full lane
- FifoFullErrSticky  output  N_LANES  sticky OR of FifoFullError
- ErrCount  output  ERR_CNT_W  saturating count of NewRegData cycles with any error
- LoadDefaultData  output  N_LANES  write default word into lane FIFO
- RdFifo  output  N_LANES  read one word from lane FIFO
- WrData  output  1  frame data valid for Aurora, one-cycle pulse
- Busy  output  1  frame sequence in progress
- FrameOverrun  output  1  pulse: SendFrame arrived while Busy and was dropped

## Operation

- All outputs registered. Reset_b low: every output 0, state IDLE, delay counter 0, immediately (asynchronous).
- Read-back path, independent of FSM state: NewRegData sampled 1 -> next cycle LoadData = LaneEn & ~FifoFull, FifoFullError = LaneEn & FifoFull; otherwise both 0.
- Sticky/counter: FifoFullErrSticky |= FifoFullError source bits; ErrCount += 1 when any error bit set, holds at 2^ERR_CNT_W-1.
- ErrClear with no new error: sticky = 0, ErrCount = 0. ErrClear with a simultaneous new error: sticky = new error bits, ErrCount = 1.
- FSM states: IDLE, FILL, READ, DELAY.
  - IDLE: SendFrame -> FILL.
  - FILL (1 cycle): LoadDefaultData = LaneEn & FifoEmpty, sampled on the entering edge; -> READ.
  - READ (1 cycle): RdFifo = LaneEn; -> DELAY, counter = WR_DLY-1.
  - DELAY: counts down; at 0, WrData pulses; -> IDLE.
- Write collision: if NewRegData and an accepted SendFrame are sampled on the same edge, LoadDefaultData excludes lanes receiving LoadData. Empty implies not full, so LoadDefaultData = 0 on enabled lanes.
- LoadData coinciding with RdFifo on a lane is legal: the FIFO is non-empty after FILL.
- Busy = state != IDLE, including the WrData cycle.
- SendFrame while Busy: FrameOverrun pulses next cycle, request discarded, sequence unaffected.
- SendFrame in the same cycle WrData is high is also dropped (still Busy).
- LaneEn = 0: FILL and READ still run with all-zero vectors and WrData is still issued.
- Reset mid-frame aborts the sequence with no WrData. Sticky flags and the counter are cleared.

## Timing

- NewRegData at edge k -> LoadData/FifoFullError high during cycle k+1.
- SendFrame at edge k in IDLE:
  - LoadDefaultData high in cycle k+1.
  - RdFifo high in cycle k+2.
  - WrData high in cycle k+2+WR_DLY.
  - Busy high in cycles k+1 .. k+2+WR_DLY.
- Minimum SendFrame spacing accepted back-to-back: 3+WR_DLY cycles.
- FrameOverrun latency: 1 cycle. ErrCount/sticky update: 1 cycle after NewRegData edge.

## Test plan

- Reset: assert Reset_b low mid-DELAY -> all outputs 0 asynchronously, no WrData; after release, SendFrame restarts from FILL.
- Default fill: N_LANES=8, WR_DLY=2, LaneEn=FF, FifoEmpty=0F, SendFrame at k -> LoadDefaultData=0F at k+1, RdFifo=FF at k+2, WrData at k+4, Busy k+1..k+4.
- Full error: LaneEn=7F, FifoFull=81, NewRegData -> LoadData=7E, FifoFullError=01 (bit7 masked), sticky=01, ErrCount=1.
- Saturation/clear: ERR_CNT_W=2, five error cycles -> ErrCount=3; ErrClear with a new error -> ErrCount=1, sticky=new bits.
- Collision: NewRegData and SendFrame same edge, FifoEmpty=FF, FifoFull=00 -> LoadData=FF, LoadDefaultData=00, RdFifo=FF next cycle.
- Overrun: second SendFrame 2 cycles after the first -> FrameOverrun pulse, exactly one WrData.
